// File: rtl/inst_axi_read_bridge.sv
// inst_axi_read_bridge
// Responder for the fetch stage's SRAM-like instruction port. Each accepted
// fetch request becomes a single-beat AXI4 read burst. Words come back in
// acceptance order because all bursts share one ARID. Up to OUTSTANDING
// requests may be accepted but not yet answered at any time.
module inst_axi_read_bridge #(
    parameter int         OUTSTANDING = 2,
    parameter logic [3:0] ARID_VAL    = 4'd0
) (
    input  logic        clk,
    input  logic        resetn,

    // fetch-stage side
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    // AXI4 read address channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    // AXI4 read data channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam int               CNT_W   = $clog2(OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             arvalid_q, arvalid_d;
    logic [31:0]      araddr_q,  araddr_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic ar_free;
    logic addr_ok;
    logic data_ok;
    logic r_ready;

    // rid/rresp/rlast carry nothing useful here: one ID, single beats, and
    // bus errors are deliberately not reported to the fetch stage.
    logic unused_inputs;
    assign unused_inputs = ^{rid, rresp, rlast};

    // Accept/return handshakes and next-state of the AR slot and the counter.
    // The full check looks only at the current count, so a response arriving
    // in the same cycle does not open a slot for a new request when full.
    always_comb begin
        ar_free   = !arvalid_q || arready;
        addr_ok   = resetn && inst_req && ar_free && (cnt_q < CNT_MAX);
        r_ready   = (cnt_q != '0);
        data_ok   = resetn && rvalid && r_ready;

        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        cnt_d     = cnt_q;

        if (addr_ok) begin
            arvalid_d = 1'b1;
            araddr_d  = inst_addr;
        end else if (arvalid_q && arready) begin
            arvalid_d = 1'b0;
        end

        case ({addr_ok, data_ok})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; the AXI fabric shares this reset, so clearing the
    // counter cannot leave a stale R beat unaccounted for.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            arvalid_q <= 1'b0;
            araddr_q  <= 32'h0;
            cnt_q     <= '0;
        end else begin
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign inst_addr_ok = addr_ok;
    assign inst_data_ok = data_ok;
    assign inst_rdata   = rdata;

    assign arid    = ARID_VAL;
    assign araddr  = araddr_q;
    assign arlen   = 8'd0;
    assign arsize  = 3'd2;
    assign arburst = 2'b01;
    assign arvalid = arvalid_q;
    assign rready  = r_ready;

endmodule

// File: tb/tb_inst_axi_read_bridge.sv
// tb_inst_axi_read_bridge
// Directed vector table for inst_axi_read_bridge plus a few hand-written
// multi-cycle sequences. Inputs change 1 ns after the rising edge and outputs
// are sampled on the falling edge.
module tb_inst_axi_read_bridge;

    typedef struct {
        logic        resetn;
        logic        req;
        logic [31:0] addr;
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        expAddrOk;
        logic        expDataOk;
        logic        expArvalid;
        logic [31:0] expAraddr;
        logic        expRready;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        instReq;
    logic [31:0] instAddr;
    logic        instAddrOk;
    logic        instDataOk;
    logic [31:0] instRdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int checks;
    int failures;
    vec_t vecs[$];

    inst_axi_read_bridge #(
        .OUTSTANDING (2),
        .ARID_VAL    (4'd0)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (instReq),
        .inst_addr    (instAddr),
        .inst_addr_ok (instAddrOk),
        .inst_data_ok (instDataOk),
        .inst_rdata   (instRdata),
        .arid         (arid),
        .araddr       (araddr),
        .arlen        (arlen),
        .arsize       (arsize),
        .arburst      (arburst),
        .arvalid      (arvalid),
        .arready      (arready),
        .rid          (rid),
        .rdata        (rdata),
        .rresp        (rresp),
        .rlast        (rlast),
        .rvalid       (rvalid),
        .rready       (rready)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Builds one table row.
    function automatic vec_t mk(input logic rst, input logic req, input logic [31:0] addr,
                                input logic ardy, input logic rv, input logic [31:0] rd,
                                input logic eAok, input logic eDok, input logic eArv,
                                input logic [31:0] eAraddr, input logic eRrdy);
        vec_t v;
        v.resetn     = rst;
        v.req        = req;
        v.addr       = addr;
        v.arready    = ardy;
        v.rvalid     = rv;
        v.rdata      = rd;
        v.expAddrOk  = eAok;
        v.expDataOk  = eDok;
        v.expArvalid = eArv;
        v.expAraddr  = eAraddr;
        v.expRready  = eRrdy;
        return v;
    endfunction

    // Drives all DUT inputs from one table row.
    task automatic applyStimulus(input vec_t v);
        resetn   = v.resetn;
        instReq  = v.req;
        instAddr = v.addr;
        arready  = v.arready;
        rvalid   = v.rvalid;
        rdata    = v.rdata;
    endtask

    // One comparison; counts it and reports a mismatch.
    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s step=%0d actual=0x%08h expected=0x%08h",
                     name, idx, actual, expected);
        end
    endtask

    // Advances to 1 ns after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        instReq  = 1'b0;
        instAddr = 32'h0;
        arready  = 1'b0;
        rid      = 4'h0;
        rdata    = 32'h0;
        rresp    = 2'b00;
        rlast    = 1'b1;
        rvalid   = 1'b0;

        //        rst req addr          ardy rv  rdata         aok dok arv araddr        rrdy
        // single fetch: accept, AR next cycle, data two cycles later
        vecs.push_back(mk(1,1,32'hBFC00000, 1,0,32'h00000000, 1,0,0,32'h00000000,0));
        vecs.push_back(mk(1,0,32'h00000000, 1,0,32'h00000000, 0,0,1,32'hBFC00000,1));
        vecs.push_back(mk(1,0,32'h00000000, 1,1,32'h3C08BFC0, 0,1,0,32'hBFC00000,1));
        vecs.push_back(mk(1,0,32'h00000000, 1,0,32'h00000000, 0,0,0,32'hBFC00000,0));
        // back-to-back requests, third held while full
        vecs.push_back(mk(1,1,32'h00001000, 1,0,32'h00000000, 1,0,0,32'hBFC00000,0));
        vecs.push_back(mk(1,1,32'h00001004, 1,0,32'h00000000, 1,0,1,32'h00001000,1));
        vecs.push_back(mk(1,1,32'h00001008, 1,0,32'h00000000, 0,0,1,32'h00001004,1));
        vecs.push_back(mk(1,1,32'h00001008, 1,0,32'h00000000, 0,0,0,32'h00001004,1));
        vecs.push_back(mk(1,1,32'h00001008, 1,1,32'h11111111, 0,1,0,32'h00001004,1));
        vecs.push_back(mk(1,1,32'h00001008, 1,0,32'h00000000, 1,0,0,32'h00001004,1));
        vecs.push_back(mk(1,0,32'h00000000, 1,1,32'h22222222, 0,1,1,32'h00001008,1));
        vecs.push_back(mk(1,0,32'h00000000, 1,1,32'h33333333, 0,1,0,32'h00001008,1));
        // AR stall for five cycles: address held, new request refused
        vecs.push_back(mk(1,1,32'h00002000, 0,0,32'h00000000, 1,0,0,32'h00001008,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1,1,32'h00002004, 0,0,32'h00000000, 0,0,1,32'h00002000,1));
        vecs.push_back(mk(1,1,32'h00002004, 1,0,32'h00000000, 1,0,1,32'h00002000,1));
        vecs.push_back(mk(1,0,32'h00000000, 1,1,32'h44444444, 0,1,1,32'h00002004,1));
        vecs.push_back(mk(1,0,32'h00000000, 1,1,32'h55555555, 0,1,0,32'h00002004,1));
        // same-cycle accept and return: allowed at cnt=1, refused at cnt=2
        vecs.push_back(mk(1,1,32'h00003000, 1,0,32'h00000000, 1,0,0,32'h00002004,0));
        vecs.push_back(mk(1,1,32'h00003004, 1,1,32'hAAAA0001, 1,1,1,32'h00003000,1));
        vecs.push_back(mk(1,1,32'h00003008, 1,0,32'h00000000, 1,0,1,32'h00003004,1));
        vecs.push_back(mk(1,1,32'h0000300C, 1,1,32'hAAAA0002, 0,1,1,32'h00003008,1));
        vecs.push_back(mk(1,0,32'h00000000, 1,1,32'hAAAA0003, 0,1,0,32'h00003008,1));
        vecs.push_back(mk(1,0,32'h00000000, 1,0,32'h00000000, 0,0,0,32'h00003008,0));
        // in-order return of two words
        vecs.push_back(mk(1,1,32'h00003000, 1,0,32'h00000000, 1,0,0,32'h00003008,0));
        vecs.push_back(mk(1,1,32'h00003004, 1,0,32'h00000000, 1,0,1,32'h00003000,1));
        vecs.push_back(mk(1,0,32'h00000000, 1,1,32'hAAAA0001, 0,1,1,32'h00003004,1));
        vecs.push_back(mk(1,0,32'h00000000, 1,1,32'hAAAA0002, 0,1,0,32'h00003004,1));
        // stray R beat with nothing outstanding is not accepted
        vecs.push_back(mk(1,0,32'h00000000, 1,1,32'hDEADBEEF, 0,0,0,32'h00003004,0));
        vecs.push_back(mk(1,0,32'h00000000, 1,0,32'h00000000, 0,0,0,32'h00003004,0));
        // reset while full with AR pending
        vecs.push_back(mk(1,1,32'h00004000, 1,0,32'h00000000, 1,0,0,32'h00003004,0));
        vecs.push_back(mk(1,1,32'h00004004, 1,0,32'h00000000, 1,0,1,32'h00004000,1));
        vecs.push_back(mk(0,1,32'h00004008, 0,0,32'h00000000, 0,0,1,32'h00004004,1));
        vecs.push_back(mk(1,0,32'h00000000, 0,1,32'h66666666, 0,0,0,32'h00000000,0));
        vecs.push_back(mk(1,1,32'h00005000, 1,0,32'h00000000, 1,0,0,32'h00000000,0));
        vecs.push_back(mk(1,0,32'h00000000, 1,1,32'h77777777, 0,1,1,32'h00005000,1));

        // initial reset, then reset-state check
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("reset_arvalid", -1, {31'b0, arvalid}, 32'h0);
        checkOutput("reset_araddr",  -1, araddr, 32'h0);
        checkOutput("reset_rready",  -1, {31'b0, rready}, 32'h0);
        checkOutput("reset_addr_ok", -1, {31'b0, instAddrOk}, 32'h0);
        checkOutput("const_arid",    -1, {28'b0, arid}, 32'h0);
        checkOutput("const_arlen",   -1, {24'b0, arlen}, 32'h0);
        checkOutput("const_arsize",  -1, {29'b0, arsize}, 32'h2);
        checkOutput("const_arburst", -1, {30'b0, arburst}, 32'h1);
        nextCycle();
        resetn = 1'b1;

        // table-driven vectors
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput("addr_ok", i, {31'b0, instAddrOk}, {31'b0, vecs[i].expAddrOk});
            checkOutput("data_ok", i, {31'b0, instDataOk}, {31'b0, vecs[i].expDataOk});
            checkOutput("arvalid", i, {31'b0, arvalid},    {31'b0, vecs[i].expArvalid});
            checkOutput("araddr",  i, araddr,              vecs[i].expAraddr);
            checkOutput("rready",  i, {31'b0, rready},     {31'b0, vecs[i].expRready});
            if (vecs[i].expDataOk)
                checkOutput("inst_rdata", i, instRdata, vecs[i].rdata);
            nextCycle();
        end

        // hand sequence: AR stalled a few cycles, bounded wait for handshake,
        // then the word returns and the bridge goes idle
        begin
            int budget;
            instReq  = 1'b0;
            rvalid   = 1'b0;
            arready  = 1'b0;
            nextCycle();
            instReq  = 1'b1;
            instAddr = 32'h00006000;
            @(negedge clk);
            checkOutput("seq_accept", 100, {31'b0, instAddrOk}, 32'h1);
            nextCycle();
            instReq = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                checkOutput("seq_stall_araddr", 101 + k, araddr, 32'h00006000);
                nextCycle();
            end
            arready = 1'b1;
            budget  = 10;
            while (arvalid && budget > 0) begin
                nextCycle();
                budget--;
            end
            checkOutput("seq_ar_timeout", 110, {31'b0, arvalid}, 32'h0);
            arready = 1'b0;
            rvalid  = 1'b1;
            rdata   = 32'h6000ABCD;
            @(negedge clk);
            checkOutput("seq_data_ok", 111, {31'b0, instDataOk}, 32'h1);
            checkOutput("seq_rdata",   112, instRdata, 32'h6000ABCD);
            nextCycle();
            rvalid = 1'b0;
            @(negedge clk);
            checkOutput("seq_idle_rready", 113, {31'b0, rready}, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
